// File: rtl/usart_tx_framer.sv
// USART transmit framer: one-entry holding buffer feeding a runtime-configurable
// start/data/parity/stop serialiser, stepped by the baud generator's bit tick.
module usart_tx_framer #(
    parameter int unsigned MAX_DATA_LEN = 9,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    bit_tick,
    input  logic                    tx_en,
    input  logic [CNT_W-1:0]        data_bits,
    input  logic [1:0]              par_mode,
    input  logic                    stop2,
    input  logic                    wr,
    input  logic [MAX_DATA_LEN-1:0] data_i,
    output logic                    udre,
    output logic                    busy,
    output logic                    tx_done,
    output logic                    txd
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } state_e;

    localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_DATA_LEN);

    state_e                  state_q, state_d;
    logic [MAX_DATA_LEN-1:0] hold_q, hold_d;
    logic [MAX_DATA_LEN-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [1:0]              par_q, par_d;
    logic                    stop2_q, stop2_d;
    logic                    par_acc_q, par_acc_d;
    logic                    udre_q, udre_d;
    logic                    txd_q, txd_d;
    logic                    tx_done_q, tx_done_d;

    logic             load;
    logic             frame_end;
    logic [CNT_W-1:0] eff_len;

    assign eff_len = ((data_bits == '0) || (data_bits > MaxLen)) ? MaxLen : data_bits;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        par_acc_d = par_acc_q;
        udre_d    = udre_q;
        tx_done_d = 1'b0;
        load      = 1'b0;
        frame_end = 1'b0;

        // Writes only land in an empty buffer; a transfer this cycle never frees it early.
        if (wr && udre_q) begin
            hold_d = data_i;
            udre_d = 1'b0;
        end

        if (bit_tick) begin
            case (state_q)
                StIdle: begin
                    if (tx_en && !udre_q) begin
                        load = 1'b1;
                    end
                end
                StStart: begin
                    state_d = StData;
                    cnt_d   = '0;
                end
                StData: begin
                    shift_d   = shift_q >> 1;
                    par_acc_d = par_acc_q ^ shift_q[0];
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = par_q[1] ? StParity : StStop1;
                    end
                end
                StParity: state_d = StStop1;
                StStop1: begin
                    if (stop2_q) begin
                        state_d = StStop2;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
                StStop2: frame_end = 1'b1;
                default: state_d = StIdle;
            endcase
        end

        if (frame_end) begin
            if (tx_en && !udre_q) begin
                load = 1'b1;
            end else begin
                state_d   = StIdle;
                tx_done_d = 1'b1;
            end
        end

        if (load) begin
            state_d   = StStart;
            shift_d   = hold_q;
            udre_d    = 1'b1;
            len_d     = eff_len;
            par_d     = par_mode;
            stop2_d   = stop2;
            par_acc_d = 1'b0;
            cnt_d     = '0;
        end

        // txd is registered, so it reflects the state being entered on this edge.
        case (state_d)
            StIdle:   txd_d = 1'b1;
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
            StParity: txd_d = par_acc_d ^ par_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            par_q     <= '0;
            stop2_q   <= 1'b0;
            par_acc_q <= 1'b0;
            udre_q    <= 1'b1;
            txd_q     <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            par_acc_q <= par_acc_d;
            udre_q    <= udre_d;
            txd_q     <= txd_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign udre    = udre_q;
    assign busy    = (state_q != StIdle);
    assign tx_done = tx_done_q;
    assign txd     = txd_q;

endmodule
